// File: rtl/rca_serial_adder.sv
// rca_serial_adder: multi-cycle WIDTH-bit unsigned adder that runs one 4-bit
// ripple-carry slice per cycle (LSB nibble first) and holds the slice carry in a
// register between cycles. One operation in flight; valid/ready on both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   operands accepted this cycle if in_valid (high only in IDLE)
//   a, b, cin  operands, sampled on in_valid && in_ready
//   out_valid  registered result valid (high only in DONE)
//   out_ready  consumer accepts result
//   sum, cout  registered result {cout,sum} = a + b + cin

// 4-bit ripple-carry slice.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module rca_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH+3:0] acc_cat;
  logic [WIDTH-1:0] acc_next;

  rca4 u_slice (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice result enters at the top; after NSLICE shifts the LSB nibble lands at bit 0.
  assign acc_cat  = {slice_sum, acc};
  assign acc_next = acc_cat[WIDTH+3:4];

  assign in_ready = (state == IDLE);

  // Control FSM plus datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          acc   <= acc_next;
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NSLICE - 1)) begin
            sum       <= acc_next;
            cout      <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rca_serial_adder.sv
// Directed bench for rca_serial_adder: a WIDTH=16 instance and a WIDTH=4 instance
// share clock and reset; each scenario task drives stimulus and checks inline.
module tb_rca_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16;
  logic [15:0] sum16;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4;
  logic [3:0]  sum4;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rca_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16)
  );

  rca_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  // Runs one op on dut16 from IDLE; returns result, edges from accept to out_valid, timeout flag.
  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          output logic [15:0] s, output logic c, output int lat, output bit to);
    to = 1'b0;
    a16 = ta; b16 = tb; cin16 = tc; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    lat = 0;
    while (!out_valid16 && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 20) to = 1'b1;
    end
    s = sum16; c = cout16;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                         output logic [3:0] s, output logic c, output int lat, output bit to);
    to = 1'b0;
    a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 20) to = 1'b1;
    end
    s = sum4; c = cout4;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] s; logic c; int lat; bit to;
    #2;
    n_cmp++;
    if ({out_valid16, in_ready16, cout16, sum16} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_initial: got ov=%b ir=%b cout=%b sum=%h, want ov=0 ir=1 cout=0 sum=0000",
               out_valid16, in_ready16, cout16, sum16);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Leave a nonzero result in DONE, then reset asynchronously mid-cycle.
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1; in_valid16 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (out_valid16 !== 1'b1 || sum16 !== 16'h5556) begin
      n_fail++;
      $display("FAIL reset_pre_done: got ov=%b sum=%h, want ov=1 sum=5556", out_valid16, sum16);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid16, in_ready16, cout16, sum16} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_async: got ov=%b ir=%b cout=%b sum=%h, want ov=0 ir=1 cout=0 sum=0000",
               out_valid16, in_ready16, cout16, sum16);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] va [4] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hFFFF};
    logic [15:0] vb [4] = '{16'h0000, 16'h0001, 16'h4321, 16'hFFFF};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h0000, 16'h0000, 16'h5556, 16'hFFFF};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] s; logic c; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op16(va[i], vb[i], vc[i], s, c, lat, to);
      n_cmp++;
      if (to || {c, s} !== {ec[i], es[i]}) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: got cout=%b sum=%h timeout=%0d, want cout=%b sum=%h",
                 i, c, s, to, ec[i], es[i]);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d edges, want 4", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1; in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int k = 0; k < 5; k++) begin
      // New operands offered while busy must be ignored.
      in_valid16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid16, in_ready16, cout16, sum16} !== {1'b1, 1'b0, 1'b0, 16'h5556}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b cout=%b sum=%h, want ov=1 ir=0 cout=0 sum=5556",
                 k, out_valid16, in_ready16, cout16, sum16);
      end
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid16 || !in_ready16) lat++;
    end
    n_cmp++;
    if (lat !== 0 || sum16 !== 16'h5556) begin
      n_fail++;
      $display("FAIL backpressure_once: got %0d busy cycles after handshake, sum=%h, want 0 and sum=5556",
               lat, sum16);
    end
  endtask

  task automatic test_abort_reset();
    logic [15:0] s; logic c; int lat; bit to; int seen;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1; in_valid16 = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid16, in_ready16} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_reset_state: got ov=%b ir=%b, want ov=0 ir=1", out_valid16, in_ready16);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid16) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_result: got out_valid high %0d cycles, want 0", seen);
    end
    run_op16(16'h0F0F, 16'h00F1, 1'b0, s, c, lat, to);
    n_cmp++;
    if (to || {c, s} !== {1'b0, 16'h1000} || lat !== 4) begin
      n_fail++;
      $display("FAIL abort_next_op: got cout=%b sum=%h lat=%0d, want cout=0 sum=1000 lat=4", c, s, lat);
    end
  endtask

  task automatic test_stream();
    logic [16:0] q [$];
    logic [16:0] exp_v;
    logic [15:0] obs_s; logic obs_c;
    bit acc_now, hs_now;
    int last_acc, n_res;
    last_acc = -1; n_res = 0;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      acc_now = in_ready16;
      hs_now = out_valid16;
      obs_s = sum16; obs_c = cout16;
      if (acc_now) q.push_back({1'b0, a16} + {1'b0, b16} + {16'h0000, cin16});
      @(posedge clk); #1;
      if (acc_now) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== 6) begin
            n_fail++;
            $display("FAIL stream_interval: got %0d cycles between accepts, want 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      if (hs_now) begin
        n_res++;
        exp_v = (q.size() > 0) ? q.pop_front() : 17'h1FFFF;
        n_cmp++;
        if ({obs_c, obs_s} !== exp_v) begin
          n_fail++;
          $display("FAIL stream_result[%0d]: got %h, want %h", n_res, {obs_c, obs_s}, exp_v);
        end
      end
    end
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    n_cmp++;
    if (n_res !== 6) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, want 6", n_res);
    end
  endtask

  task automatic test_width4();
    logic [3:0] va [3] = '{4'hF, 4'h4, 4'hF};
    logic [3:0] vb [3] = '{4'h1, 4'h1, 4'hF};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] es [3] = '{4'h0, 4'h6, 4'hF};
    logic       ec [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] s; logic c; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op4(va[i], vb[i], vc[i], s, c, lat, to);
      n_cmp++;
      if (to || {c, s} !== {ec[i], es[i]} || lat !== 1) begin
        n_fail++;
        $display("FAIL width4[%0d]: got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=1",
                 i, c, s, lat, ec[i], es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort_reset();
    test_stream();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
